// File: rtl/scroll_msg_display_if.sv
// Message-buffer load bus for scroll_msg_display: write strobe, glyph address and glyph data.
interface scroll_msg_display_if #(
    parameter int MSG_LEN = 8
);
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [6:0]    load_data;

    modport master (output load_we, output load_addr, output load_data);
    modport slave  (input  load_we, input  load_addr, input  load_data);
endinterface

// File: rtl/scroll_msg_display.sv
// Single-clock scrolling-message controller for an active-low seven-segment bank.
// Optional macro SCROLL_DIR_EN adds a 'dir' input selecting right-to-left scrolling.
module scroll_msg_display #(
    parameter int NDIG    = 8,
    parameter int MSG_LEN = 8,
    parameter int CLK_DIV = 6250000,
    parameter int NSPEED  = 5,
    parameter int SPD_RST = 2
) (
    input  logic                      CLOCK_50,
    input  logic                      Resetn,
    input  logic                      clear,
    input  logic                      run,
    input  logic                      faster_n,
    input  logic                      slower_n,
`ifdef SCROLL_DIR_EN
    input  logic                      dir,
`endif
    scroll_msg_display_if.slave       load,
    output logic [7*NDIG-1:0]         hex,
    output logic [$clog2(NSPEED)-1:0] speed,
    output logic                      scroll_tick,
    output logic                      filling
);
    localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int SW = $clog2(NSPEED);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(NDIG + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_LEN - 1);
    localparam logic [SW-1:0] SPD_MAX   = SW'(NSPEED - 1);
    localparam logic [SW-1:0] SPD_INIT  = SW'(SPD_RST);
    localparam logic [CW-1:0] FILL_LAST = CW'(NDIG - 1);
    localparam logic [6:0]    BLANK     = 7'h7F;

    typedef enum logic {FILL, LOOP} state_t;

    state_t            state, state_next;
    logic [PW-1:0]     pre_cnt;
    logic [NSPEED-1:0] spd_cnt;
    logic [NSPEED-1:0] spd_mask;
    logic              base_tick;
    logic              shift_en;
    logic [1:0]        fast_sync, slow_sync;
    logic              fast_prev, slow_prev;
    logic              fast_press, slow_press;
    logic [SW-1:0]     speed_next;
    logic [CW-1:0]     fill_cnt;
    logic [AW-1:0]     ptr, ptr_next;
    logic              dir_sel;
    logic [6:0]        digits      [NDIG];
    logic [6:0]        digits_next [NDIG];
    logic [6:0]        msg_buf     [MSG_LEN];

    function automatic logic [6:0] hello_glyph(input int idx);
        case (idx)
            0:       return 7'h48;
            1:       return 7'h30;
            2:       return 7'h71;
            3:       return 7'h71;
            4:       return 7'h01;
            default: return 7'h7F;
        endcase
    endfunction

`ifdef SCROLL_DIR_EN
    assign dir_sel = dir;
`else
    assign dir_sel = 1'b0;
`endif

    // Base tick prescaler; holding run low freezes it mid-count rather than restarting it.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            pre_cnt <= '0;
        end else if (clear) begin
            pre_cnt <= '0;
        end else if (run) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
        end
    end

    assign base_tick = run && (pre_cnt == PRE_LAST);

    always_comb begin
        spd_mask = '0;
        for (int i = 0; i < NSPEED; i++) begin
            spd_mask[i] = (SW'(i) <= speed);
        end
    end

    assign shift_en = base_tick && ((spd_cnt & spd_mask) == spd_mask);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            spd_cnt <= '0;
        end else if (clear) begin
            spd_cnt <= '0;
        end else if (base_tick) begin
            spd_cnt <= spd_cnt + NSPEED'(1);
        end
    end

    // Keys idle high, so the synchronisers reset to 1 to avoid a phantom press after reset.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            fast_sync <= 2'b11;
            slow_sync <= 2'b11;
            fast_prev <= 1'b1;
            slow_prev <= 1'b1;
        end else begin
            fast_sync <= {fast_sync[0], faster_n};
            slow_sync <= {slow_sync[0], slower_n};
            fast_prev <= fast_sync[1];
            slow_prev <= slow_sync[1];
        end
    end

    assign fast_press = fast_prev && !fast_sync[1];
    assign slow_press = slow_prev && !slow_sync[1];

    always_comb begin
        speed_next = speed;
        if (fast_press && !slow_press && speed != '0) begin
            speed_next = speed - SW'(1);
        end else if (slow_press && !fast_press && speed != SPD_MAX) begin
            speed_next = speed + SW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            speed <= SPD_INIT;
        end else if (clear) begin
            speed <= SPD_INIT;
        end else begin
            speed <= speed_next;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        filling    = 1'b0;
        case (state)
            FILL: begin
                filling = 1'b1;
                if (shift_en && fill_cnt == FILL_LAST) begin
                    state_next = LOOP;
                end
            end
            LOOP: state_next = LOOP;
            default: state_next = FILL;
        endcase
        if (clear) begin
            state_next = FILL;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            fill_cnt <= '0;
        end else if (clear) begin
            fill_cnt <= '0;
        end else if (shift_en && state == FILL) begin
            fill_cnt <= fill_cnt + CW'(1);
        end
    end

    // Next display contents for either scroll direction; the entering glyph always comes from buf[ptr].
    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            digits_next[i] = digits[i];
        end
        ptr_next = ptr;
        if (dir_sel) begin
            for (int i = 0; i < NDIG - 1; i++) begin
                digits_next[i] = digits[i+1];
            end
            digits_next[NDIG-1] = msg_buf[ptr];
            ptr_next = (ptr == '0) ? LAST_ADDR : ptr - AW'(1);
        end else begin
            for (int i = 1; i < NDIG; i++) begin
                digits_next[i] = digits[i-1];
            end
            digits_next[0] = msg_buf[ptr];
            ptr_next = (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NDIG; i++) begin
                digits[i] <= BLANK;
            end
            ptr         <= '0;
            scroll_tick <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NDIG; i++) begin
                digits[i] <= BLANK;
            end
            ptr         <= '0;
            scroll_tick <= 1'b0;
        end else begin
            scroll_tick <= shift_en;
            if (shift_en) begin
                for (int i = 0; i < NDIG; i++) begin
                    digits[i] <= digits_next[i];
                end
                ptr <= ptr_next;
            end
        end
    end

    // clear leaves the buffer alone; a write racing a shift of the same slot lands after the read.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_buf[i] <= hello_glyph(i);
            end
        end else if (load.load_we) begin
            msg_buf[load.load_addr] <= load.load_data;
        end
    end

    always_comb begin
        hex = '0;
        for (int i = 0; i < NDIG; i++) begin
            hex[7*i +: 7] = digits[i];
        end
    end
endmodule

// File: tb/tb_scroll_msg_display.sv
// Directed self-checking bench for scroll_msg_display with a fast prescaler (CLK_DIV=4).
module tb_scroll_msg_display;
    localparam int NDIG    = 8;
    localparam int MSG_LEN = 8;
    localparam int CLK_DIV = 4;
    localparam int NSPEED  = 5;
    localparam int SPD_RST = 2;

    localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        run;
    logic        faster_n;
    logic        slower_n;
    logic [55:0] hex;
    logic [2:0]  speed;
    logic        scroll_tick;
    logic        filling;
`ifdef SCROLL_DIR_EN
    logic        dir;
`endif

    int checks   = 0;
    int failures = 0;
    int tick_total = 0;
    int n;
    int held_ticks;
    int guard;

    logic [6:0] msg_model [8] = '{7'h48, 7'h30, 7'h71, 7'h71, 7'h01, 7'h7F, 7'h7F, 7'h7F};

    scroll_msg_display_if #(.MSG_LEN(MSG_LEN)) load_bus ();

    scroll_msg_display #(
        .NDIG(NDIG), .MSG_LEN(MSG_LEN), .CLK_DIV(CLK_DIV), .NSPEED(NSPEED), .SPD_RST(SPD_RST)
    ) dut (
        .CLOCK_50(clk),
        .Resetn(rst_n),
        .clear(clear),
        .run(run),
        .faster_n(faster_n),
        .slower_n(slower_n),
`ifdef SCROLL_DIR_EN
        .dir(dir),
`endif
        .load(load_bus),
        .hex(hex),
        .speed(speed),
        .scroll_tick(scroll_tick),
        .filling(filling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count shifts since the last reset/clear so the display can be predicted from the message.
    always begin
        @(posedge clk);
        #1;
        if (!rst_n || clear) tick_total = 0;
        else if (scroll_tick) tick_total = tick_total + 1;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic press_fast, input logic press_slow);
        @(negedge clk);
        faster_n = ~press_fast;
        slower_n = ~press_slow;
        repeat (4) @(negedge clk);
        faster_n = 1'b1;
        slower_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_for_tick(input int limit, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #2;
            cycles++;
        end while (!scroll_tick && cycles < limit);
        checkOutput("tick_seen", 64'(scroll_tick), 64'd1);
    endtask

    function automatic logic [55:0] expected_hex(input int k);
        logic [55:0] h;
        int idx;
        h = '0;
        for (int j = 0; j < 8; j++) begin
            idx = k - 1 - j;
            h[7*j +: 7] = (idx < 0) ? 7'h7F : msg_model[idx % 8];
        end
        return h;
    endfunction

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        run      = 1'b1;
        faster_n = 1'b1;
        slower_n = 1'b1;
`ifdef SCROLL_DIR_EN
        dir      = 1'b0;
`endif
        load_bus.load_we   = 1'b0;
        load_bus.load_addr = '0;
        load_bus.load_data = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_hex", 64'(hex), 64'(ALL_BLANK));
        checkOutput("rst_speed", 64'(speed), 64'd2);
        checkOutput("rst_filling", 64'(filling), 64'd1);
        checkOutput("rst_tick", 64'(scroll_tick), 64'd0);
        rst_n = 1'b1;

        // Fill phase at speed 2: one shift every 32 cycles.
        wait_for_tick(100, n);
        checkOutput("first_tick_cycle", 64'(n), 64'd32);
        checkOutput("first_hex", 64'(hex), 64'({{7{7'h7F}}, 7'h48}));
        checkOutput("first_filling", 64'(filling), 64'd1);
        for (int i = 0; i < 6; i++) begin
            wait_for_tick(100, n);
            checkOutput("fill_gap", 64'(n), 64'd32);
        end
        checkOutput("filling_at7", 64'(filling), 64'd1);
        wait_for_tick(100, n);
        checkOutput("gap_8th", 64'(n), 64'd32);
        checkOutput("hex_8th", 64'(hex), 64'({7'h48, 7'h30, 7'h71, 7'h71, 7'h01, 7'h7F, 7'h7F, 7'h7F}));
        checkOutput("filling_8th", 64'(filling), 64'd0);
        wait_for_tick(100, n);
        checkOutput("hex_9th_wrap", 64'(hex), 64'({7'h30, 7'h71, 7'h71, 7'h01, 7'h7F, 7'h7F, 7'h7F, 7'h48}));

        // Faster key saturates at 0.
        applyStimulus(1'b1, 1'b0);
        checkOutput("speed_fast1", 64'(speed), 64'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("speed_fast2", 64'(speed), 64'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("speed_fast_sat", 64'(speed), 64'd0);
        wait_for_tick(300, n);
        wait_for_tick(300, n);
        checkOutput("gap_speed0", 64'(n), 64'd8);
        checkOutput("hex_speed0", 64'(hex), 64'(expected_hex(tick_total)));

        // Hold with run=0 three cycles after a shift; five run cycles remain afterwards.
        wait_for_tick(100, n);
        repeat (3) @(posedge clk);
        @(negedge clk);
        run = 1'b0;
        held_ticks = 0;
        repeat (100) begin
            @(posedge clk);
            #2;
            if (scroll_tick) held_ticks++;
        end
        checkOutput("hold_no_tick", 64'(held_ticks), 64'd0);
        checkOutput("hold_hex", 64'(hex), 64'(expected_hex(tick_total)));
        @(negedge clk);
        run = 1'b1;
        wait_for_tick(100, n);
        checkOutput("resume_remaining", 64'(n), 64'd5);
        checkOutput("resume_hex", 64'(hex), 64'(expected_hex(tick_total)));

        // Overwrite buf[0] on the very edge that the shift reads ptr=0.
        guard = 0;
        do begin
            wait_for_tick(100, n);
            guard++;
        end while ((tick_total % 8) != 0 && guard < 10);
        checkOutput("align_ptr0", 64'(tick_total % 8), 64'd0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        load_bus.load_we   = 1'b1;
        load_bus.load_addr = '0;
        load_bus.load_data = 7'h00;
        wait_for_tick(100, n);
        checkOutput("load_same_edge", 64'(n), 64'd1);
        @(negedge clk);
        load_bus.load_we = 1'b0;
        checkOutput("load_old_glyph", 64'(hex[6:0]), 64'h48);
        repeat (8) wait_for_tick(100, n);
        checkOutput("load_new_glyph", 64'(hex[6:0]), 64'h00);

        // Slower key saturates at NSPEED-1.
        applyStimulus(1'b0, 1'b1);
        checkOutput("speed_slow1", 64'(speed), 64'd1);
        repeat (4) applyStimulus(1'b0, 1'b1);
        checkOutput("speed_slow_sat", 64'(speed), 64'd4);
        wait_for_tick(300, n);
        wait_for_tick(300, n);
        checkOutput("gap_speed4", 64'(n), 64'd128);
        applyStimulus(1'b1, 1'b1);
        checkOutput("speed_both_keys", 64'(speed), 64'd4);

        // Synchronous clear mid-LOOP.
        checkOutput("loop_before_clear", 64'(filling), 64'd0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("clear_hex", 64'(hex), 64'(ALL_BLANK));
        checkOutput("clear_speed", 64'(speed), 64'd2);
        checkOutput("clear_filling", 64'(filling), 64'd1);
        checkOutput("clear_tick", 64'(scroll_tick), 64'd0);
        @(negedge clk);
        clear = 1'b0;
        wait_for_tick(100, n);
        checkOutput("clear_first_cycle", 64'(n), 64'd32);
        checkOutput("clear_buf_kept", 64'(hex), 64'({{7{7'h7F}}, 7'h00}));

        // Asynchronous reset between clock edges, then the message reloads as HELLO.
        applyStimulus(1'b0, 1'b1);
        checkOutput("speed_pre_reset", 64'(speed), 64'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_hex", 64'(hex), 64'(ALL_BLANK));
        checkOutput("async_rst_speed", 64'(speed), 64'd2);
        checkOutput("async_rst_filling", 64'(filling), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for_tick(100, n);
        checkOutput("reset_first_cycle", 64'(n), 64'd32);
        checkOutput("reset_buf_reload", 64'(hex), 64'({{7{7'h7F}}, 7'h48}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scroll_msg_display.md
Name: scroll_msg_display

Overview:
- Parametrised scrolling-message controller for an NDIG-digit active-low seven-segment bank.
- Feeds glyphs from a loadable message buffer into digit 0 and shifts them toward digit NDIG-1 at one of NSPEED selectable rates.
- Fully synchronous single-clock successor to the derived-clock scroller: tick enables replace gated clocks, and keys are synchronised and edge-detected.
- Sits between board switches/keys and the HEX outputs in DE2 lab tops.

Parameters:
- NDIG, 8, number of seven-segment digits driven.
- MSG_LEN, 8, message buffer depth in glyphs (>=2).
- CLK_DIV, 6250000, CLOCK_50 cycles per base tick.
- NSPEED, 5, number of speed levels (>=2).
- SPD_RST, 2, speed level loaded at reset/clear (< NSPEED).

Ports:
- CLOCK_50  in  1  system clock.
- Resetn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous blank/restart, level-sensitive, highest priority.
- run  in  1  1 = scrolling, 0 = hold current display.
- faster_n  in  1  active-low key, asynchronous to clock.
- slower_n  in  1  active-low key, asynchronous to clock.
- load_we  in  1  message buffer write strobe.
- load_addr  in  clog2(MSG_LEN)  write address.
- load_data  in  7  glyph, active-low, bit6 = seg a … bit0 = seg g.
- hex  out  7*NDIG  digit i = hex[7*i+6:7*i], same bit order as load_data.
- speed  out  clog2(NSPEED)  current level, 0 = fastest.
- scroll_tick  out  1  one-cycle pulse on each shift.
- filling  out  1  high while in FILL.

Behaviour:
- Reset (Resetn=0, async) and clear (sync):
  - all digits 7'h7F (blank); ptr=0; speed=SPD_RST; prescaler=0; speed counter=0; state FILL; scroll_tick=0.
  - clear does not alter the message buffer. Resetn also loads it with "HELLO" at addresses 0..4 (7'h48,7'h30,7'h71,7'h71,7'h01) and 7'h7F elsewhere. If MSG_LEN<5, only the first MSG_LEN entries are loaded.
- Prescaler:
  - counts 0..CLK_DIV-1 then wraps; base_tick=1 for the single cycle at count CLK_DIV-1.
  - freezes while run=0.
- Speed counter (NSPEED bits, free-running, wraps):
  - increments on base_tick.
  - shift_en = base_tick && (speed_cnt[speed:0] all ones, pre-increment), so the scroll period is 2^(speed+1) base ticks.
  - A speed change never resets the counter and takes effect on the next base_tick.
- Keys:
  - 2-FF synchroniser, then press = falling edge of the synchronised level.
  - faster press: speed-1, saturating at 0. slower press: speed+1, saturating at NSPEED-1.
  - Both presses in the same cycle: no change.
  - Presses during clear are ignored.
- Shift (on shift_en, registered outputs):
  - digit[i] <= digit[i-1] for i=NDIG-1..1; digit[0] <= buf[ptr].
  - ptr <= (ptr==MSG_LEN-1) ? 0 : ptr+1.
  - scroll_tick is high the same cycle the new hex value appears.
- States:
  - FILL: counts shifts; after NDIG shifts → LOOP; filling=1 only in FILL.
  - LOOP: identical shifting, so the message recirculates with period MSG_LEN shifts.
  - HOLD is not a state: run=0 freezes the prescaler and ptr, and the display is held.
- Buffer write:
  - synchronous, allowed in any state.
  - Write to buf[ptr] in the same cycle that shift consumes it: the shift uses the old glyph and the new one is used on the next wrap.
- Latency: key edge to speed change = 3 cycles (2 sync + 1 register).

Optional Feature:
- Macro SCROLL_DIR_EN.
- Defined: adds input dir (1 bit, sampled at shift_en).
  - dir=0: behaviour as above.
  - dir=1: digit[i] <= digit[i+1], digit[NDIG-1] <= buf[ptr], ptr decrements with wrap MSG_LEN-1.
  - A dir change mid-message continues from the current ptr with no blanking.
- Undefined: no dir port; left-shift only.

Test Plan:
- CLK_DIV=4, NSPEED=5, Resetn pulse → hex all 7'h7F, speed=2, filling=1. First scroll_tick at cycle 8·4=32 after release: digit0=7'h48, others 7'h7F.
- Same config, 8 shifts → hex reads H,E,L,L,O,blank,blank,blank from digit7 down to digit0, filling=0. The 9th shift sets digit0=7'h48 again (wrap).
- Three faster_n presses → speed 2→1→0 (saturates, stays 0), inter-tick gap 8 cycles. Five slower_n presses → speed=4, gap 128 cycles. Both keys pressed in the same cycle → unchanged.
- run=0 mid-message for 100 cycles → hex and ptr frozen, no scroll_tick. run=1 → next tick occurs the remaining prescaler count later, not restarted.
- load_we addr 0 data 7'h00 in the same cycle shift reads ptr=0 → digit0 gets 7'h48; after MSG_LEN further shifts digit0=7'h00.
- clear asserted mid-LOOP at speed 4 → next cycle all 7'h7F, speed=2, filling=1, buffer contents preserved. Resetn asserted mid-cycle → outputs blank immediately, with no clock edge needed.
